// File: rtl/stopwatch_timer_pkg.sv
// ============================================================================
// stopwatch_pkg : shared types and digit limits for the stopwatch core
// Rev 1.0
// ============================================================================
`default_nettype none

package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  localparam bcd_t c_LIMIT_DEC  = 4'd9;
  localparam bcd_t c_LIMIT_SEXT = 4'd5;

endpackage

`default_nettype wire

// File: rtl/stopwatch_timer_if.sv
// ============================================================================
// stopwatch_timer_if : command pulses in, BCD display word and status out
// Rev 1.0
// ============================================================================
`default_nettype none

interface stopwatch_timer_if;

  logic        start_stop;
  logic        lap;
  logic        clear;
  logic [15:0] encoded;
  logic        running;
  logic        lapped;
  logic        minute_pulse;

  modport master (
    output start_stop, lap, clear,
    input  encoded, running, lapped, minute_pulse
  );

  modport slave (
    input  start_stop, lap, clear,
    output encoded, running, lapped, minute_pulse
  );

endinterface

`default_nettype wire

// File: rtl/stopwatch_timer_bcd_digit.sv
// ============================================================================
// bcd_digit : one cascadable BCD counter digit wrapping at LIMIT
// Rev 1.0
// ============================================================================
`default_nettype none

module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter bcd_t LIMIT = c_LIMIT_DEC
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output bcd_t q,
  output logic carry
);

  bcd_t r_q;

  // >= rather than == so a corrupted value can never stick above the limit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= (r_q >= LIMIT) ? '0 : r_q + 4'd1;
    end
  end

  assign q     = r_q;
  assign carry = en && (r_q == LIMIT);

endmodule

`default_nettype wire

// File: rtl/stopwatch_timer.sv
// ============================================================================
// stopwatch_timer : SS.hh BCD stopwatch with start/stop, lap and clear control
// Rev 1.0
// ============================================================================
`default_nettype none

module stopwatch_timer
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic               clk,
  input  logic               rst,
  stopwatch_timer_if.slave   bus
);

  localparam int             DIV          = CLK_HZ / TICK_HZ;
  localparam int             PW           = $clog2(DIV);
  localparam logic [PW-1:0]  c_PRESC_LAST = PW'(DIV - 1);

  state_t        r_state;
  state_t        w_next_state;
  logic [PW-1:0] r_presc;
  logic [15:0]   r_snap;
  logic          r_running;
  logic          r_lapped;
  logic          r_minute;
  logic          w_active;
  logic          w_tick;
  logic          w_clr;
  logic          w_capture;
  bcd_t          w_q0, w_q1, w_q2, w_q3;
  logic          w_c0, w_c1, w_c2, w_c3;
  logic [15:0]   w_live;

  assign w_active = (r_state == RUN) || (r_state == LAP);
  assign w_tick   = w_active && (r_presc == c_PRESC_LAST);
  assign w_live   = {w_q3, w_q2, w_q1, w_q0};

  // Commands illegal in the current state fall through to the next priority
  always_comb begin
    w_next_state = r_state;
    w_clr        = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start_stop) w_next_state = RUN;
      end
      RUN: begin
        if (bus.start_stop) begin
          w_next_state = PAUSE;
        end else if (bus.lap) begin
          w_next_state = LAP;
          w_capture    = 1'b1;
        end
      end
      LAP: begin
        if (bus.start_stop)  w_next_state = PAUSE;
        else if (bus.lap)    w_next_state = RUN;
      end
      PAUSE: begin
        if (bus.clear) begin
          w_next_state = IDLE;
          w_clr        = 1'b1;
        end else if (bus.start_stop) begin
          w_next_state = RUN;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
      r_lapped  <= 1'b0;
      r_minute  <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_running <= (w_next_state == RUN) || (w_next_state == LAP);
      r_lapped  <= (w_next_state == LAP);
      r_minute  <= w_c3;
    end
  end

  // Prescaler holds its value while paused so no partial tick is lost
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
    end else if (w_clr) begin
      r_presc <= '0;
    end else if (w_active) begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_snap <= '0;
    end else if (w_clr) begin
      r_snap <= '0;
    end else if (w_capture) begin
      r_snap <= w_live;
    end
  end

  bcd_digit #(.LIMIT(c_LIMIT_DEC)) u_hund_ones (
    .clk(clk), .rst(rst), .clr(w_clr), .en(w_tick), .q(w_q0), .carry(w_c0)
  );
  bcd_digit #(.LIMIT(c_LIMIT_DEC)) u_hund_tens (
    .clk(clk), .rst(rst), .clr(w_clr), .en(w_c0),   .q(w_q1), .carry(w_c1)
  );
  bcd_digit #(.LIMIT(c_LIMIT_DEC)) u_sec_ones (
    .clk(clk), .rst(rst), .clr(w_clr), .en(w_c1),   .q(w_q2), .carry(w_c2)
  );
  bcd_digit #(.LIMIT(c_LIMIT_SEXT)) u_sec_tens (
    .clk(clk), .rst(rst), .clr(w_clr), .en(w_c2),   .q(w_q3), .carry(w_c3)
  );

  assign bus.encoded      = r_lapped ? r_snap : w_live;
  assign bus.running      = r_running;
  assign bus.lapped       = r_lapped;
  assign bus.minute_pulse = r_minute;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_timer.sv
// ============================================================================
// tb_stopwatch_timer : directed self-checking bench, CLK_HZ=1000, TICK_HZ=100
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_stopwatch_timer;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  stopwatch_timer_if sw ();

  stopwatch_timer #(
    .CLK_HZ (1000),
    .TICK_HZ(100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the command is sampled by the next posedge
  task automatic cmd(input logic ss, input logic lp, input logic cl);
    sw.start_stop = ss;
    sw.lap        = lp;
    sw.clear      = cl;
    @(negedge clk);
    sw.start_stop = 1'b0;
    sw.lap        = 1'b0;
    sw.clear      = 1'b0;
  endtask

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    edges(2);
    rst = 1'b1;
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    sw.start_stop = 1'b0;
    sw.lap        = 1'b0;
    sw.clear      = 1'b0;
    rst           = 1'b1;
    @(negedge clk);

    // Reset values and first-tick latency
    do_reset();
    check("rst_encoded", sw.encoded, 16'h0000);
    check("rst_running", {15'd0, sw.running}, 16'd0);
    check("rst_lapped",  {15'd0, sw.lapped}, 16'd0);
    check("rst_minute",  {15'd0, sw.minute_pulse}, 16'd0);
    cmd(1'b0, 1'b1, 1'b1);
    check("idle_ignores_lap_clear", {15'd0, sw.running}, 16'd0);
    cmd(1'b1, 1'b0, 1'b0);
    check("start_running", {15'd0, sw.running}, 16'd1);
    edges(9);
    check("edge9_no_tick", sw.encoded, 16'h0000);
    edges(1);
    check("edge10_first_tick", sw.encoded, 16'h0001);
    edges(90);
    check("edge100", sw.encoded, 16'h0010);

    // Full minute wrap
    edges(59890);
    check("at_5999", sw.encoded, 16'h5999);
    edges(9);
    check("still_5999", sw.encoded, 16'h5999);
    check("no_minute_yet", {15'd0, sw.minute_pulse}, 16'd0);
    edges(1);
    check("wrap_0000", sw.encoded, 16'h0000);
    check("minute_high", {15'd0, sw.minute_pulse}, 16'd1);
    edges(1);
    check("minute_one_cycle", {15'd0, sw.minute_pulse}, 16'd0);
    check("after_wrap", sw.encoded, 16'h0000);

    // Lap freeze and release
    do_reset();
    cmd(1'b1, 1'b0, 1'b0);
    edges(1230);
    check("pre_lap", sw.encoded, 16'h0123);
    cmd(1'b0, 1'b1, 1'b0);
    check("lap_lapped", {15'd0, sw.lapped}, 16'd1);
    check("lap_running", {15'd0, sw.running}, 16'd1);
    check("lap_frozen", sw.encoded, 16'h0123);
    edges(499);
    check("lap_frozen_50", sw.encoded, 16'h0123);
    cmd(1'b0, 1'b1, 1'b0);
    check("lap_release_lapped", {15'd0, sw.lapped}, 16'd0);
    check("lap_release_live", sw.encoded, 16'h0173);

    // Pause keeps prescaler, clear rules
    do_reset();
    cmd(1'b1, 1'b0, 1'b0);
    edges(6);
    cmd(1'b1, 1'b0, 1'b0);
    check("pause_running", {15'd0, sw.running}, 16'd0);
    edges(100);
    check("pause_hold", sw.encoded, 16'h0000);
    cmd(1'b0, 1'b1, 1'b0);
    check("pause_ignores_lap", {15'd0, sw.lapped}, 16'd0);
    cmd(1'b1, 1'b0, 1'b0);
    check("resume_running", {15'd0, sw.running}, 16'd1);
    edges(2);
    check("resume_plus2", sw.encoded, 16'h0000);
    edges(1);
    check("resume_plus3", sw.encoded, 16'h0001);
    cmd(1'b0, 1'b0, 1'b1);
    check("run_clear_ignored_cnt", sw.encoded, 16'h0001);
    check("run_clear_ignored_run", {15'd0, sw.running}, 16'd1);
    cmd(1'b1, 1'b0, 1'b0);
    cmd(1'b0, 1'b0, 1'b1);
    check("clear_encoded", sw.encoded, 16'h0000);
    check("clear_running", {15'd0, sw.running}, 16'd0);
    cmd(1'b1, 1'b0, 1'b0);
    edges(9);
    check("clear_presc_9", sw.encoded, 16'h0000);
    edges(1);
    check("clear_presc_10", sw.encoded, 16'h0001);

    // Coincident commands
    do_reset();
    cmd(1'b1, 1'b0, 1'b0);
    edges(30);
    check("pre_coinc", sw.encoded, 16'h0003);
    cmd(1'b1, 1'b1, 1'b0);
    check("ss_beats_lap_lapped", {15'd0, sw.lapped}, 16'd0);
    check("ss_beats_lap_running", {15'd0, sw.running}, 16'd0);
    cmd(1'b1, 1'b0, 1'b1);
    check("clear_beats_ss_enc", sw.encoded, 16'h0000);
    check("clear_beats_ss_run", {15'd0, sw.running}, 16'd0);

    // Asynchronous reset mid-run
    cmd(1'b1, 1'b0, 1'b0);
    edges(25);
    check("pre_async", sw.encoded, 16'h0002);
    #2;
    rst = 1'b0;
    #1;
    check("async_encoded", sw.encoded, 16'h0000);
    check("async_running", {15'd0, sw.running}, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    edges(15);
    check("post_reset_idle_enc", sw.encoded, 16'h0000);
    check("post_reset_idle_run", {15'd0, sw.running}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
